// File: rtl/byte_strip_n_pkg.sv
// byte_strip_n shared definitions: link-layer token values, FSM states
// and a saturating counter helper, shared with the future un-striper.
package byte_strip_n_pkg;

    localparam logic [7:0] TOK_STP = 8'hFB;
    localparam logic [7:0] TOK_SDP = 8'h5C;
    localparam logic [7:0] TOK_END = 8'hFD;
    localparam logic [7:0] TOK_EDB = 8'hFE;
    localparam logic [7:0] TOK_COM = 8'hBC;
    localparam logic [7:0] TOK_SKP = 8'h1C;
    localparam logic [7:0] TOK_IDL = 8'h7C;

    typedef enum logic {
        COLLECT = 1'b0,
        PAD     = 1'b1
    } state_t;

    function automatic logic [7:0] sat_add8(logic [7:0] a, logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/byte_strip_n_if.sv
// byte_strip_n bus: serial symbol input (d, dk, in_valid/in_ready) and
// striped word output (lane_data, lane_dk, out_valid) with error reporting.
interface byte_strip_n_if #(
    parameter int LANES = 4,
    parameter int BITS  = 8
);
    logic [BITS-1:0]       d;
    logic                  dk;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*BITS-1:0] lane_data;
    logic [LANES-1:0]      lane_dk;
    logic                  out_valid;
    logic                  err_dk;
    logic                  err_pos;
    logic [7:0]            err_cnt;

    modport master (
        output d, dk, in_valid,
        input  in_ready, lane_data, lane_dk, out_valid,
        input  err_dk, err_pos, err_cnt
    );

    modport slave (
        input  d, dk, in_valid,
        output in_ready, lane_data, lane_dk, out_valid,
        output err_dk, err_pos, err_cnt
    );
endinterface

// File: rtl/byte_strip_n_token_check.sv
// Combinational token classifier. Ports: d/dk symbol, cnt current lane;
// is_start, is_end, dk_err, pos_err, need_pad classification outputs.
module byte_strip_n_token_check
    import byte_strip_n_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BITS  = 8,
    localparam int CW   = $clog2(LANES)
) (
    input  logic [BITS-1:0] d,
    input  logic            dk,
    input  logic [CW-1:0]   cnt,
    output logic            is_start,
    output logic            is_end,
    output logic            dk_err,
    output logic            pos_err,
    output logic            need_pad
);
    assign is_start = (d == BITS'(TOK_STP)) || (d == BITS'(TOK_SDP));
    assign is_end   = (d == BITS'(TOK_END)) || (d == BITS'(TOK_EDB));

    // Framing tokens travel with DK=0, everything else with DK=1.
    assign dk_err   = (is_start || is_end) ? dk : !dk;
    assign pos_err  = is_end && (cnt != CW'(LANES - 1));
    assign need_pad = is_start && (cnt != '0);
endmodule

// File: rtl/byte_strip_n.sv
// Serial-to-parallel lane striper with framing checks and IDL realignment.
// Ports: clk, reset (sync, active-high), bus (byte_strip_n_if.slave).
module byte_strip_n
    import byte_strip_n_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BITS  = 8
) (
    input logic         clk,
    input logic         reset,
    byte_strip_n_if.slave bus
);
    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [LANES-1:0][BITS-1:0] slot_q;
    logic [LANES-1:0][BITS-1:0] word_d;
    logic [LANES-1:0]        slot_k;
    logic [LANES-1:0]        word_k;
    logic [LANES*BITS-1:0]   lane_data_q;
    logic [LANES-1:0]        lane_dk_q;
    logic                    out_valid_q;
    logic                    err_dk_q;
    logic                    err_pos_q;
    logic [7:0]              err_cnt_q;

    logic is_start, is_end, dk_err, pos_err, need_pad;
    logic class_unused;
    logic ready, wr, pad, acc, fire, e_dk, e_pos;

    byte_strip_n_token_check #(
        .LANES (LANES),
        .BITS  (BITS)
    ) u_check (
        .d        (bus.d),
        .dk       (bus.dk),
        .cnt      (cnt),
        .is_start (is_start),
        .is_end   (is_end),
        .dk_err   (dk_err),
        .pos_err  (pos_err),
        .need_pad (need_pad)
    );

    assign class_unused = is_start | is_end;

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    // A misplaced start token is held off; the detection cycle already
    // writes the first IDL so the stall lasts exactly LANES-k cycles.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        wr        = 1'b0;
        pad       = 1'b0;
        unique case (state)
            COLLECT: begin
                ready = !need_pad;
                if (bus.in_valid) begin
                    wr  = 1'b1;
                    pad = need_pad;
                    if (need_pad && cnt != LAST) state_nxt = PAD;
                end
            end
            PAD: begin
                wr  = 1'b1;
                pad = 1'b1;
                if (cnt == LAST) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    assign acc   = wr && !pad;
    assign fire  = wr && (cnt == LAST);
    assign e_dk  = acc && dk_err;
    assign e_pos = acc && pos_err;

    always_comb begin
        word_d      = slot_q;
        word_k      = slot_k;
        word_d[cnt] = pad ? BITS'(TOK_IDL) : bus.d;
        word_k[cnt] = pad ? 1'b1 : bus.dk;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            slot_q      <= '0;
            slot_k      <= '0;
            lane_data_q <= '0;
            lane_dk_q   <= '0;
            out_valid_q <= 1'b0;
            err_dk_q    <= 1'b0;
            err_pos_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= fire;
            err_dk_q    <= e_dk;
            err_pos_q   <= e_pos;
            err_cnt_q   <= sat_add8(err_cnt_q,
                                    {1'b0, e_dk} + {1'b0, e_pos});
            if (wr) begin
                slot_q <= word_d;
                slot_k <= word_k;
                cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
            if (fire) begin
                lane_data_q <= word_d;
                lane_dk_q   <= word_k;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.lane_data = lane_data_q;
    assign bus.lane_dk   = lane_dk_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_dk    = err_dk_q;
    assign bus.err_pos   = err_pos_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_byte_strip_n.sv
// Bench for byte_strip_n: stream model with word/error queues checked
// every cycle, plus hand-computed directed expectations.
module tb_byte_strip_n;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst8 = 1'b1;
    always #5 clk = ~clk;

    byte_strip_n_if #(.LANES(4), .BITS(8)) bus ();
    byte_strip_n_if #(.LANES(8), .BITS(8)) bus8 ();

    byte_strip_n #(.LANES(4), .BITS(8)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    byte_strip_n #(.LANES(8), .BITS(8)) dut8 (
        .clk   (clk),
        .reset (rst8),
        .bus   (bus8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stream model: symbols fill lanes in order; a start token off lane 0
    // first fills the rest of the word with IDL.
    logic [7:0]  cur_d[$];
    bit          cur_k[$];
    logic [31:0] exp_w[$];
    logic [3:0]  exp_k[$];
    bit          exp_edk[$];
    bit          exp_epos[$];
    int          mcnt = 0;

    function automatic void m_place(input logic [7:0] d, input bit k);
        logic [31:0] w;
        logic [3:0]  kk;
        cur_d.push_back(d);
        cur_k.push_back(k);
        if (cur_d.size() == L) begin
            for (int i = 0; i < L; i++) begin
                w[i*8 +: 8] = cur_d[i];
                kk[i]       = cur_k[i];
            end
            exp_w.push_back(w);
            exp_k.push_back(kk);
            cur_d.delete();
            cur_k.delete();
        end
    endfunction

    function automatic bit is_st(input logic [7:0] d);
        return d == 8'hFB || d == 8'h5C;
    endfunction

    function automatic bit is_en(input logic [7:0] d);
        return d == 8'hFD || d == 8'hFE;
    endfunction

    function automatic void m_prepad(input logic [7:0] d);
        if (is_st(d))
            while (cur_d.size() != 0) m_place(8'h7C, 1'b1);
    endfunction

    function automatic void m_accept(input logic [7:0] d, input bit k);
        bit edk, epos;
        edk  = (is_st(d) || is_en(d)) ? (k != 1'b0) : (k != 1'b1);
        epos = is_en(d) && (cur_d.size() != L - 1);
        m_place(d, k);
        if (edk || epos) begin
            exp_edk.push_back(edk);
            exp_epos.push_back(epos);
        end
        mcnt += int'(edk) + int'(epos);
        if (mcnt > 255) mcnt = 255;
    endfunction

    logic [31:0] ov_w[$];
    logic [3:0]  ov_k[$];
    int          ov_cyc[$];
    int          cyc = 0;
    int          ov8 = 0;

    always @(negedge clk) begin
        cyc++;
        chk("err_cnt", bus.err_cnt, 64'(mcnt));
        if (bus.out_valid) begin
            ov_w.push_back(bus.lane_data);
            ov_k.push_back(bus.lane_dk);
            ov_cyc.push_back(cyc);
            if (exp_w.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_extra: got %h expected none",
                         bus.lane_data);
            end else begin
                chk("word", bus.lane_data, exp_w.pop_front());
                chk("word_dk", bus.lane_dk, exp_k.pop_front());
            end
        end
        if (bus.err_dk || bus.err_pos) begin
            if (exp_edk.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL err_extra: got dk=%b pos=%b expected none",
                         bus.err_dk, bus.err_pos);
            end else begin
                chk("err_dk_flag", bus.err_dk, exp_edk.pop_front());
                chk("err_pos_flag", bus.err_pos, exp_epos.pop_front());
            end
        end
        if (bus8.out_valid) ov8++;
    end

    task automatic send(input logic [7:0] d, input bit k, output int stalls);
        bit r;
        int n;
        n = 0;
        stalls = 0;
        m_prepad(d);
        bus.d = d;
        bus.dk = k;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (!r) stalls++;
            n++;
        end while (!r && n < 50);
        bus.in_valid = 1'b0;
        chk("accept", r, 1);
        if (r) m_accept(d, k);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_d.delete();
        cur_k.delete();
        mcnt = 0;
    endtask

    int st;
    int b;

    initial begin
        bus.d = 8'h00;
        bus.dk = 1'b1;
        bus.in_valid = 1'b0;
        bus8.d = 8'h00;
        bus8.dk = 1'b1;
        bus8.in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        rst8 = 1'b0;

        chk("rst_data", bus.lane_data, 0);
        chk("rst_dk", bus.lane_dk, 0);
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_edk", bus.err_dk, 0);
        chk("rst_epos", bus.err_pos, 0);
        chk("rst_ready", bus.in_ready, 1);

        b = ov_w.size();
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b1, st);
            if (i == 3) chk("lat_pre", bus.out_valid, 0);
            if (i == 4) chk("lat", bus.out_valid, 1);
        end
        idle(2);
        chk("t1_n", ov_w.size() - b, 2);
        chk("t1_w0", ov_w[b], 32'h04030201);
        chk("t1_w1", ov_w[b+1], 32'h08070605);
        chk("t1_gap", ov_cyc[b+1] - ov_cyc[b], 4);

        b = ov_w.size();
        send(8'hFB, 1'b0, st);
        send(8'h11, 1'b1, st);
        send(8'h22, 1'b1, st);
        send(8'hFD, 1'b0, st);
        idle(2);
        chk("t2_w", ov_w[b], 32'hFD2211FB);
        chk("t2_k", ov_k[b], 4'b0110);

        b = ov_w.size();
        send(8'h33, 1'b1, st);
        send(8'h44, 1'b1, st);
        send(8'hFB, 1'b0, st);
        chk("t3_stall", st, 2);
        send(8'h55, 1'b1, st);
        send(8'h66, 1'b1, st);
        send(8'hFD, 1'b0, st);
        idle(2);
        chk("t3_pad", ov_w[b], 32'h7C7C4433);
        chk("t3_pad_k", ov_k[b], 4'b1111);
        chk("t3_next", ov_w[b+1], 32'hFD6655FB);
        chk("t3_cnt", bus.err_cnt, 0);

        b = ov_w.size();
        send(8'h77, 1'b1, st);
        send(8'hFD, 1'b1, st);
        chk("t4_edk", bus.err_dk, 1);
        chk("t4_epos", bus.err_pos, 1);
        chk("t4_cnt", bus.err_cnt, 2);
        send(8'h88, 1'b1, st);
        chk("t4_clr", bus.err_pos, 0);
        send(8'hFD, 1'b0, st);
        idle(2);
        chk("t4_w", ov_w[b], 32'hFD88FD77);
        chk("t4_k", ov_k[b], 4'b0111);

        b = ov_w.size();
        send(8'hA1, 1'b1, st);
        send(8'hA2, 1'b1, st);
        send(8'hA3, 1'b1, st);
        do_reset();
        chk("t5_rcnt", bus.err_cnt, 0);
        send(8'hB1, 1'b1, st);
        idle(3);
        send(8'hB2, 1'b1, st);
        send(8'hB3, 1'b1, st);
        send(8'hB4, 1'b1, st);
        idle(2);
        chk("t5_n", ov_w.size() - b, 1);
        chk("t5_w", ov_w[b], 32'hB4B3B2B1);

        b = ov_w.size();
        send(8'h01, 1'b1, st);
        send(8'hFB, 1'b1, st);
        chk("t6_stall", st, 3);
        chk("t6_edk", bus.err_dk, 1);
        chk("t6_epos", bus.err_pos, 0);
        send(8'h02, 1'b1, st);
        send(8'h03, 1'b1, st);
        send(8'h04, 1'b1, st);
        idle(2);
        chk("t6_pad", ov_w[b], 32'h7C7C7C01);
        chk("t6_next", ov_w[b+1], 32'h040302FB);
        chk("t6_k", ov_k[b+1], 4'b1111);

        b = ov_w.size();
        send(8'h10, 1'b1, st);
        send(8'h20, 1'b1, st);
        send(8'h30, 1'b1, st);
        send(8'h5C, 1'b0, st);
        chk("t7_stall", st, 1);
        send(8'h40, 1'b1, st);
        send(8'h50, 1'b1, st);
        send(8'hFE, 1'b0, st);
        idle(2);
        chk("t7_pad", ov_w[b], 32'h7C302010);
        chk("t7_next", ov_w[b+1], 32'hFE50405C);
        chk("t7_cnt", bus.err_cnt, 1);

        bus8.d = 8'h01;
        bus8.dk = 1'b0;
        bus8.in_valid = 1'b1;
        idle(254);
        chk("l8_fe", bus8.err_cnt, 8'hFE);
        idle(46);
        bus8.in_valid = 1'b0;
        idle(2);
        chk("l8_sat", bus8.err_cnt, 8'hFF);
        chk("l8_words", ov8, 37);
        chk("l8_data", bus8.lane_data, 64'h0101010101010101);
        chk("l8_dk", bus8.lane_dk, 8'h00);

        chk("left_words", exp_w.size(), 0);
        chk("left_errs", exp_edk.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_strip_n.md
# byte_strip_n

Parametrised successor to the fixed 4-lane byte striper. It sits between the link-layer byte source and the per-lane 8b/10b encoders. It collects a serial byte stream into LANES-wide aligned words and emits all lanes in the same cycle. It checks framing-token placement and the DK flag, and realigns misplaced start tokens by padding with IDL.

## Interface
- LANES, 4: lane count, 2..16.
- BITS, 8: symbol width per lane.
- CW, $clog2(LANES): lane-counter width (derived, not overridden).
- CLK  in  1: sole clock, rising edge.
- RESET  in  1: synchronous, active-high reset. Reset is synchronous and active-high.
- D  in  BITS: input symbol.
- DK  in  1: symbol class, codebase convention: 0 = framing token (STP/SDP/END/EDB), 1 = data/IDL/SKP/COM.
- IN_VALID  in  1: D/DK are valid this cycle.
- IN_READY  out  1: block accepts D this cycle. The transfer happens when IN_VALID && IN_READY.
- LANE_DATA  out  LANES*BITS: striped word; lane i occupies bits [i*BITS +: BITS].
- LANE_DK  out  LANES: DK per lane.
- OUT_VALID  out  1: one-cycle pulse, LANE_* hold a complete word. Downstream never stalls.
- ERR_DK  out  1: pulse, DK does not match the symbol class of an accepted byte.
- ERR_POS  out  1: pulse, END/EDB accepted on a lane other than LANES-1.
- ERR_CNT  out  8: saturating count of error events (DK and position errors both count; simultaneous counts as 2).

## Operation
- Tokens: STP 8'hFB, SDP 8'h5C, END 8'hFD, EDB 8'hFE. Expected DK is 0. Every other value expects DK=1.
- Lane counter CNT (CW bits) gives the lane of the next accepted byte.
- On accept, the byte goes to slot CNT of the assembly buffer and CNT advances. When CNT==LANES-1, the buffer plus the current byte is registered to LANE_DATA/LANE_DK, OUT_VALID pulses, and CNT wraps to 0.
- FSM has two states, COLLECT and PAD.
- In COLLECT, IN_READY=1.
- STP/SDP with CNT!=0: the byte is not accepted (IN_READY=0 that cycle, combinational from D). The FSM enters PAD and writes IDL (8'h7C, DK=1) into the remaining lanes, one lane per cycle. When the word completes, it returns to COLLECT with CNT=0, and the held STP/SDP is then accepted on lane 0. The padding is not an error.
- In PAD, IN_READY=0.
- END/EDB on a lane other than LANES-1 raises ERR_POS. The byte is placed as received and there is no padding.
- A DK mismatch raises ERR_DK. The byte is still forwarded unchanged.
- A token that is both misplaced and has bad DK: for END/EDB, assert both flags in the same cycle. For STP/SDP, assert ERR_DK on the cycle the token is accepted after padding.
- IN_VALID=0 holds CNT and the buffer. A partial word waits indefinitely.
- ERR_CNT saturates at 8'hFF.

## Timing
- Reset values: LANE_DATA=0, LANE_DK=0, OUT_VALID=0, ERR_DK=0, ERR_POS=0, ERR_CNT=0, CNT=0, FSM=COLLECT, buffer cleared.
- IN_READY is 1 on the first cycle after reset, unless D is a start token under the padding rule.
- Reset mid-word discards the partial word with no OUT_VALID. Reset during PAD aborts the padding.
- Latency: if the lane LANES-1 byte is accepted in cycle t, OUT_VALID=1 in cycle t+1.
- Error flags are registered and assert in cycle t+1 for a byte accepted in cycle t. ERR_CNT updates in the same cycle.
- PAD with a start token seen at lane k lasts LANES-k cycles. OUT_VALID fires the cycle after the last pad write, and the token is accepted that same cycle.
- Throughput is one byte per cycle, so one word every LANES cycles when there is no padding.

## Structure
- Shared header `byte_strip_defs.vh` holds the token constants (STP, SDP, END, EDB, COM, SKP, IDL) and the FSM state encodings. It is shared with the future un-striper.
- Sub-module `strip_token_check`: combinational. Inputs are D, DK, CNT, LANES. Outputs are is_start, is_end, dk_err, pos_err, need_pad.

## Test plan
- LANES=4, send 8 data bytes 01..08 (DK=1) back-to-back -> two OUT_VALID pulses, 4 cycles apart; LANE_DATA=32'h04030201 then 32'h08070605; no errors.
- STP (DK=0) on lane 0, 2 data bytes, END on lane 3 -> word {FD,d2,d1,FB}; ERR_CNT=0.
- 2 data bytes, then STP -> IN_READY low 2 cycles; word {7C,7C,d2,d1}; next word starts with FB in lane 0; no error.
- END on lane 1 with DK=1 -> ERR_POS and ERR_DK both pulse in the same cycle; ERR_CNT increments by 2; byte appears in lane 1.
- 3 bytes accepted, RESET asserted 1 cycle, then 4 bytes -> only one OUT_VALID, carrying the post-reset bytes.
- LANES=8, 300 DK errors -> ERR_CNT holds 8'hFF.
